in5out2_bist: RTL and testbench

Self-checking stimulus/response engine for the `in5out2` selector block: the hardware counterpart of its bench. On a `Start` pulse it drives a pseudo-random sequence of `D`/`A`/`B`/`C`/`Sel` vectors into `in5out2` and checks the returned `Out`/`Out_Bar` against an internal reference model. It counts mismatches and reports pass/fail. It sits beside `in5out2` in the board-level wrapper and is used for power-on self-test.

---
 rtl/in5out2_bist.sv | 175 +++++++++++++++++
 tb/tb_in5out2_bist.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/in5out2_bist.sv
// rtl/in5out2_bist.sv - power-on self-test engine for the in5out2 selector
//
// Purpose:
//   On a Start pulse, drives NUM_VECTORS pseudo-random D/A/B/C/Sel vectors
//   into in5out2. Each response is checked against an internal reference
//   model, and the block reports mismatch counts and pass/fail.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   Start           run request, honoured only in IDLE or DONE
//   D, A, B, C, Sel registered stimulus to in5out2
//   Out, Out_Bar    responses from in5out2
//   Busy            high from the first APPLY through the last CHECK
//   Done, Pass      run finished / finished with zero mismatches
//   Fail_Pulse      one-cycle pulse on each mismatching vector
//   Err_Count       mismatching vectors in the current or last run
//   Vec_Count       vectors checked so far
//   First_Fail_Idx  index of the first failing vector, 8'hFF if none

module in5out2_bist #(
    parameter int unsigned NUM_VECTORS   = 100,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    output logic [2:0] D,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       Sel,
    input  logic       Out,
    input  logic       Out_Bar,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic       Fail_Pulse,
    output logic [7:0] Err_Count,
    output logic [7:0] Vec_Count,
    output logic [7:0] First_Fail_Idx
);

    // An all-zero seed would lock the LFSR at zero, so substitute 1.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  LAST_IDX  = 8'(NUM_VECTORS - 1);
    localparam logic [3:0]  WAIT_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  NO_FAIL   = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [6:0]  stim_q, stim_d;       // {Sel, C, B, A, D[2:0]}
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  err_q, err_d;
    logic [7:0]  vec_q, vec_d;
    logic [7:0]  ffi_q, ffi_d;
    logic        fail_pulse_q, fail_pulse_d;

    logic [15:0] lfsr_step;
    logic        exp_bit;
    logic        mismatch;
    logic        start_ok;

    // Galois right-shift LFSR, taps 16'hB400.
    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    // Reference model works from the registered stimulus, i.e. exactly what
    // in5out2 is currently seeing.
    assign exp_bit  = stim_q[6] ? ~(stim_q[3] ^ stim_q[4] ^ stim_q[5])
                                : ((stim_q[0] & stim_q[1]) | stim_q[2]);
    // A vector failing both rails still counts once.
    assign mismatch = (Out != exp_bit) || (Out_Bar != ~exp_bit);

    assign start_ok = Start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // State register and datapath flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED_EFF;
            stim_q       <= 7'd0;
            wait_q       <= 4'd0;
            err_q        <= 8'd0;
            vec_q        <= 8'd0;
            ffi_q        <= NO_FAIL;
            fail_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            stim_q       <= stim_d;
            wait_q       <= wait_d;
            err_q        <= err_d;
            vec_q        <= vec_d;
            ffi_q        <= ffi_d;
            fail_pulse_q <= fail_pulse_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE,
            S_DONE:  if (Start) state_d = S_APPLY;
            S_APPLY: state_d = S_WAIT;
            S_WAIT:  if (wait_q == WAIT_LAST) state_d = S_CHECK;
            S_CHECK: state_d = (vec_q == LAST_IDX) ? S_DONE : S_APPLY;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        lfsr_d       = lfsr_q;
        stim_d       = stim_q;
        wait_d       = wait_q;
        err_d        = err_q;
        vec_d        = vec_q;
        ffi_d        = ffi_q;
        fail_pulse_d = 1'b0;

        if (start_ok) begin
            lfsr_d = SEED_EFF;
            err_d  = 8'd0;
            vec_d  = 8'd0;
            ffi_d  = NO_FAIL;
        end

        case (state_q)
            S_APPLY: begin
                stim_d = lfsr_q[6:0];
                wait_d = 4'd0;
            end
            S_WAIT: begin
                wait_d = wait_q + 4'd1;
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d        = err_q + 8'd1;
                    fail_pulse_d = 1'b1;
                    if (ffi_q == NO_FAIL) ffi_d = vec_q;
                end
                vec_d  = vec_q + 8'd1;
                lfsr_d = lfsr_step;
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        Busy = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_CHECK);
        Done = (state_q == S_DONE);
        Pass = (state_q == S_DONE) && (err_q == 8'd0);
    end

    assign D              = stim_q[2:0];
    assign A              = stim_q[3];
    assign B              = stim_q[4];
    assign C              = stim_q[5];
    assign Sel            = stim_q[6];
    assign Fail_Pulse     = fail_pulse_q;
    assign Err_Count      = err_q;
    assign Vec_Count      = vec_q;
    assign First_Fail_Idx = ffi_q;

endmodule

// File: tb/tb_in5out2_bist.sv
// tb/tb_in5out2_bist.sv - self-checking bench for in5out2_bist

module tb_in5out2_bist;

    localparam int          NV   = 100;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    int   fault_mode = 0;   // 0 good, 1 Out stuck 0, 2 Out_Bar tied to Out

    int checks   = 0;
    int failures = 0;

    // Main instance (defaults)
    logic [2:0] d0;
    logic       a0, b0, c0, sel0, out0, out_bar0, exp0;
    logic       busy0, done0, pass0, fp0;
    logic [7:0] err0, vec0, ffi0;

    assign exp0     = sel0 ? ~(a0 ^ b0 ^ c0) : ((d0[0] & d0[1]) | d0[2]);
    assign out0     = (fault_mode == 1) ? 1'b0 : exp0;
    assign out_bar0 = (fault_mode == 2) ? out0 : ~out0;

    in5out2_bist #(.NUM_VECTORS(NV), .SETTLE_CYCLES(1), .SEED(SEED)) dut0 (
        .CLK(clk), .RST(rst), .Start(start0),
        .D(d0), .A(a0), .B(b0), .C(c0), .Sel(sel0),
        .Out(out0), .Out_Bar(out_bar0),
        .Busy(busy0), .Done(done0), .Pass(pass0), .Fail_Pulse(fp0),
        .Err_Count(err0), .Vec_Count(vec0), .First_Fail_Idx(ffi0)
    );

    // Short-run instance: one vector, three settle cycles
    logic [2:0] d1;
    logic       a1, b1, c1, sel1, out1;
    logic       busy1, done1, pass1, fp1;
    logic [7:0] err1, vec1, ffi1;

    assign out1 = sel1 ? ~(a1 ^ b1 ^ c1) : ((d1[0] & d1[1]) | d1[2]);

    in5out2_bist #(.NUM_VECTORS(1), .SETTLE_CYCLES(3), .SEED(SEED)) dut1 (
        .CLK(clk), .RST(rst), .Start(start1),
        .D(d1), .A(a1), .B(b1), .C(c1), .Sel(sel1),
        .Out(out1), .Out_Bar(~out1),
        .Busy(busy1), .Done(done1), .Pass(pass1), .Fail_Pulse(fp1),
        .Err_Count(err1), .Vec_Count(vec1), .First_Fail_Idx(ffi1)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic logic ref_exp(input logic [6:0] v);
        return v[6] ? ~(v[3] ^ v[4] ^ v[5]) : ((v[0] & v[1]) | v[2]);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_stim"}, 16'({sel0, c0, b0, a0, d0}), 16'h0);
        check({tag, "_busy"}, 16'(busy0), 16'h0);
        check({tag, "_done"}, 16'(done0), 16'h0);
        check({tag, "_pass"}, 16'(pass0), 16'h0);
        check({tag, "_fp"},   16'(fp0),   16'h0);
        check({tag, "_err"},  16'(err0),  16'h0);
        check({tag, "_vec"},  16'(vec0),  16'h0);
        check({tag, "_ffi"},  16'(ffi0),  16'hFF);
    endtask

    // One run on dut0. poke_k: pulse Start before vector poke_k's APPLY edge.
    // abort_k: assert RST (with Start) in place of vector abort_k.
    task automatic run0(input int fault, input int poke_k, input int abort_k);
        logic [15:0] l;
        logic [6:0]  vq[$];
        logic [6:0]  v;
        logic        mm;
        int          errs;
        int          ffi;

        fault_mode = fault;
        l = SEED;
        for (int k = 0; k < NV; k++) begin
            vq.push_back(l[6:0]);
            l = lfsr_next(l);
        end
        errs = 0;
        ffi  = 255;

        start0 = 1'b1;
        @(negedge clk);                     // just past t0
        start0 = 1'b0;
        check("t0_busy", 16'(busy0), 16'h1);
        check("t0_done", 16'(done0), 16'h0);
        check("t0_err",  16'(err0),  16'h0);
        check("t0_vec",  16'(vec0),  16'h0);
        check("t0_ffi",  16'(ffi0),  16'hFF);

        for (int k = 0; k < NV; k++) begin
            if (k == abort_k) begin
                rst    = 1'b1;
                start0 = 1'b1;
                @(negedge clk);
                rst    = 1'b0;
                start0 = 1'b0;
                check_reset0("midrun_rst");
                return;
            end
            if (k == poke_k) start0 = 1'b1;
            @(negedge clk);                 // APPLY edge t0+1+3k
            start0 = 1'b0;
            v = vq.pop_front();
            check("stim", 16'({sel0, c0, b0, a0, d0}), 16'(v));
            check("fp_apply", 16'(fp0), 16'h0);
            @(negedge clk);
            @(negedge clk);                 // CHECK edge t0+3(k+1)
            mm = (fault == 2) ? 1'b1 : (fault == 1) ? ref_exp(v) : 1'b0;
            if (mm) begin
                errs++;
                if (ffi == 255) ffi = k;
            end
            check("fail_pulse", 16'(fp0),   16'(mm));
            check("err_count",  16'(err0),  16'(errs));
            check("vec_count",  16'(vec0),  16'(k + 1));
            check("first_fail", 16'(ffi0),  16'(ffi));
            check("busy",       16'(busy0), 16'(k != NV - 1));
            check("done",       16'(done0), 16'(k == NV - 1));
        end
        check("end_pass", 16'(pass0), 16'(errs == 0));
        if (fault == 1) check("stuck0_ffi", 16'(ffi0), 16'h1);
        if (fault == 2) begin
            check("tied_err", 16'(err0), 16'd100);
            check("tied_ffi", 16'(ffi0), 16'h0);
        end
        @(negedge clk);                     // DONE holds
        check("hold_done", 16'(done0), 16'(1));
        check("hold_vec",  16'(vec0),  16'(NV));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset0("reset");
        check("reset_done1", 16'(done1), 16'h0);
        check("reset_ffi1",  16'(ffi1),  16'hFF);
        rst = 1'b0;

        run0(0, 7, -1);     // golden, with an ignored Start during the run
        run0(1, -1, -1);    // Out stuck at 0
        run0(2, -1, -1);    // Out_Bar tied to Out
        run0(0, -1, 50);    // reset during vector 50
        run0(0, -1, -1);    // same sequence again from IDLE

        // Short run: first pass, then restart from DONE
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("s1_busy", 16'(busy1), 16'h1);
        repeat (4) @(negedge clk);
        check("s1_done_early", 16'(done1), 16'h0);
        @(negedge clk);
        check("s1_done", 16'(done1), 16'h1);
        check("s1_vec",  16'(vec1),  16'h1);

        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("s2_done_drop", 16'(done1), 16'h0);
        check("s2_pass_drop", 16'(pass1), 16'h0);
        check("s2_vec_clr",   16'(vec1),  16'h0);
        check("s2_err_clr",   16'(err1),  16'h0);
        check("s2_busy",      16'(busy1), 16'h1);
        @(negedge clk);
        check("s2_stim", 16'({sel1, c1, b1, a1, d1}), 16'(SEED[6:0]));
        repeat (3) @(negedge clk);
        check("s2_done_early", 16'(done1), 16'h0);
        @(negedge clk);
        check("s2_done", 16'(done1), 16'h1);
        check("s2_vec",  16'(vec1),  16'h1);
        check("s2_pass", 16'(pass1), 16'h1);
        check("s2_ffi",  16'(ffi1),  16'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
